// File: rtl/washer_pkg.sv
// rtl/washer_pkg.sv - shared types and helpers for the washer timing stage
// Holds the timer state enum, the prescaler width helper and the
// controller's state codes used when decoding the spin request.
package washer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WASH      = 3'd1,
        ST_SPIN      = 3'd2,
        ST_WASH_DONE = 3'd3,
        ST_SPIN_DONE = 3'd4
    } timer_state_t;

    // Controller state codes; a spin request is a decode of CTRL_SPIN.
    typedef enum logic [2:0] {
        CTRL_IDLE  = 3'd0,
        CTRL_FILL  = 3'd1,
        CTRL_WASH  = 3'd2,
        CTRL_DRAIN = 3'd3,
        CTRL_SPIN  = 3'd4
    } ctrl_state_t;

    // Prescaler width: clog2 of the period, never narrower than 1 bit.
    function automatic int tick_w(input int clk_per_tick);
        return (clk_per_tick <= 2) ? 1 : $clog2(clk_per_tick);
    endfunction

    function automatic logic is_spin_state(input ctrl_state_t s);
        return s == CTRL_SPIN;
    endfunction

endpackage

// File: rtl/wash_spin_timer_if.sv
// rtl/wash_spin_timer_if.sv - request/timeout bundle between controller and timer
// master: controller side (drives requests, pause, durations; reads timeouts).
// slave:  timer side (reads requests; drives timeouts, remaining, busy).
interface wash_spin_timer_if #(
    parameter int CNT_W = 12
);
    import washer_pkg::*;

    logic             wash_run;
    logic             spin_run;
    logic             pause;
    logic [CNT_W-1:0] wash_ticks;
    logic [CNT_W-1:0] spin_ticks;
    logic             cycle_timeout;
    logic             spin_timeout;
    logic [CNT_W-1:0] remaining;
    logic             busy;

    modport master (
        output wash_run, spin_run, pause, wash_ticks, spin_ticks,
        input  cycle_timeout, spin_timeout, remaining, busy
    );

    modport slave (
        input  wash_run, spin_run, pause, wash_ticks, spin_ticks,
        output cycle_timeout, spin_timeout, remaining, busy
    );

endinterface

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running clock-to-tick prescaler
// Ports: clk, reset (async active-low), en (advance), clr (sync clear,
// wins over en), tick (high while the counter sits at CLK_PER_TICK-1).
module tick_prescaler
    import washer_pkg::*;
#(
    parameter int CLK_PER_TICK = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int TICK_W = tick_w(CLK_PER_TICK);
    localparam logic [TICK_W-1:0] LAST = TICK_W'(CLK_PER_TICK - 1);

    logic [TICK_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + TICK_W'(1);
        end
    end

    // Not qualified by en: the timer decides whether this cycle counts.
    assign tick = (cnt == LAST);

endmodule

// File: rtl/wash_spin_timer.sv
// rtl/wash_spin_timer.sv - wash/spin phase timer feeding the controller timeouts
// Ports: clk, reset (async active-low), bus (slave side of wash_spin_timer_if:
// wash_run/spin_run/pause/wash_ticks/spin_ticks in; cycle_timeout/
// spin_timeout/remaining/busy out, all registered).
module wash_spin_timer
    import washer_pkg::*;
#(
    parameter int CLK_PER_TICK = 100,
    parameter int CNT_W        = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    wash_spin_timer_if.slave     bus
);
    timer_state_t     state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             presc_en, presc_clr, tick;
    logic             run;
    timer_state_t     done_st;

    logic             cycle_timeout_q, cycle_timeout_d;
    logic             spin_timeout_q, spin_timeout_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             busy_q, busy_d;

    tick_prescaler #(.CLK_PER_TICK(CLK_PER_TICK)) u_presc (
        .clk   (clk),
        .reset (reset),
        .en    (presc_en),
        .clr   (presc_clr),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            count_q         <= '0;
            cycle_timeout_q <= 1'b0;
            spin_timeout_q  <= 1'b0;
            remaining_q     <= '0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            cycle_timeout_q <= cycle_timeout_d;
            spin_timeout_q  <= spin_timeout_d;
            remaining_q     <= remaining_d;
            busy_q          <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        presc_en  = 1'b0;
        presc_clr = 1'b1;   // prescaler is held at 0 unless a phase keeps running
        run       = 1'b0;
        done_st   = ST_WASH_DONE;

        unique case (state_q)
            ST_IDLE: begin
                count_d = '0;
                if (bus.wash_run) begin
                    state_d = ST_WASH;
                    count_d = bus.wash_ticks;
                end else if (bus.spin_run) begin
                    state_d = ST_SPIN;
                    count_d = bus.spin_ticks;
                end
            end

            ST_WASH, ST_SPIN: begin
                run     = (state_q == ST_WASH) ? bus.wash_run : bus.spin_run;
                done_st = (state_q == ST_WASH) ? ST_WASH_DONE : ST_SPIN_DONE;
                if (!run) begin
                    // Abort takes priority, even over a completion this cycle.
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (bus.pause) begin
                    presc_clr = 1'b0;
                end else if (count_q == '0) begin
                    state_d = done_st;
                end else if (tick && count_q == CNT_W'(1)) begin
                    // Completion pre-empts the 1 -> 0 decrement.
                    state_d = done_st;
                    count_d = '0;
                end else begin
                    presc_en  = 1'b1;
                    presc_clr = 1'b0;
                    if (tick) begin
                        count_d = count_q - CNT_W'(1);
                    end
                end
            end

            ST_WASH_DONE: begin
                count_d = '0;
                if (!bus.wash_run) state_d = ST_IDLE;
            end

            ST_SPIN_DONE: begin
                count_d = '0;
                if (!bus.spin_run) state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        busy_d          = (state_d == ST_WASH) || (state_d == ST_SPIN);
        remaining_d     = busy_d ? count_d : '0;
        cycle_timeout_d = (state_d == ST_WASH_DONE);
        spin_timeout_d  = (state_d == ST_SPIN_DONE);
    end

    assign bus.cycle_timeout = cycle_timeout_q;
    assign bus.spin_timeout  = spin_timeout_q;
    assign bus.remaining     = remaining_q;
    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_wash_spin_timer.sv
// tb/tb_wash_spin_timer.sv - randomized scoreboard bench for wash_spin_timer
module tb_wash_spin_timer;
    localparam int P = 4;
    localparam int W = 12;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    wash_spin_timer_if #(.CNT_W(W)) bus ();

    wash_spin_timer #(.CLK_PER_TICK(P), .CNT_W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit is_spin;
        int at;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic got_timeout(input bit is_spin);
        exp_t e;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_timeout: got spin=%0d at cycle %0d expected none", is_spin, cyc);
        end else begin
            e = sbq.pop_front();
            chk("timeout_kind", int'(is_spin), int'(e.is_spin));
            chk("timeout_cycle", cyc, e.at);
        end
    endtask

    // Monitor: every rising timeout must match the head of the scoreboard.
    logic prev_ct = 1'b0;
    logic prev_st = 1'b0;
    always @(negedge clk) begin
        if (bus.cycle_timeout && !prev_ct) got_timeout(1'b0);
        if (bus.spin_timeout && !prev_st) got_timeout(1'b1);
        prev_ct <= bus.cycle_timeout;
        prev_st <= bus.spin_timeout;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_busy"}, int'(bus.busy), 0);
        chk({nm, "_remaining"}, int'(bus.remaining), 0);
        chk({nm, "_cycle_to"}, int'(bus.cycle_timeout), 0);
        chk({nm, "_spin_to"}, int'(bus.spin_timeout), 0);
    endtask

    // kind: 0 wash, 1 spin, 2 both (wash expected). pmode: 0 none, 1 window,
    // 2 random. abort_req: 0 none, -1 random interval, else that interval.
    task automatic run_txn(input int kind, input int nw, input int ns,
                           input int pmode, input int pstart, input int plen,
                           input int abort_req);
        bit pz[256];
        int n, need, u, t, a, e0, hold;
        n    = (kind == 1) ? ns : nw;
        need = (n == 0) ? 1 : n * P;
        u = 0;
        t = 0;
        // Phase ends on the interval that supplies the last needed unpaused cycle.
        while (u < need) begin
            t++;
            if (pmode == 1)      pz[t] = (t >= pstart) && (t < pstart + plen);
            else if (pmode == 2) pz[t] = (t < 200) && ($urandom_range(0, 3) == 0);
            else                 pz[t] = 1'b0;
            if (!pz[t]) u++;
        end
        a = (abort_req < 0) ? int'($urandom_range(1, t)) : abort_req;

        bus.wash_ticks = W'(nw);
        bus.spin_ticks = W'(ns);
        bus.wash_run   = (kind != 1);
        bus.spin_run   = (kind != 0);
        bus.pause      = 1'b0;
        step();
        e0 = cyc;
        if (a == 0) sbq.push_back('{is_spin: (kind == 1), at: e0 + t});
        chk("remaining_start", int'(bus.remaining), n);
        chk("busy_start", int'(bus.busy), 1);

        u = 0;
        for (int i = 1; i <= t; i++) begin
            bus.pause = pz[i];
            if (i == a) begin
                bus.wash_run = 1'b0;
                bus.spin_run = 1'b0;
            end
            bus.wash_ticks = W'($urandom_range(0, 15));
            bus.spin_ticks = W'($urandom_range(0, 15));
            step();
            if (!pz[i]) u++;
            if (i == a) begin
                chk_idle("abort");
                break;
            end
            if (i < t) begin
                chk("remaining", int'(bus.remaining), n - u / P);
                chk("busy_phase", int'(bus.busy), 1);
            end else begin
                chk("busy_done", int'(bus.busy), 0);
                chk("remaining_done", int'(bus.remaining), 0);
            end
        end
        bus.pause = 1'b0;

        if (a == 0) begin
            hold = $urandom_range(0, 2);
            repeat (hold) begin
                step();
                chk("timeout_held",
                    int'((kind == 1) ? bus.spin_timeout : bus.cycle_timeout), 1);
            end
            bus.wash_run = 1'b0;
            bus.spin_run = 1'b0;
            step();
            chk_idle("release");
        end else begin
            step();
            chk_idle("after_abort");
        end
    endtask

    initial begin
        bus.wash_run   = 1'b0;
        bus.spin_run   = 1'b0;
        bus.pause      = 1'b0;
        bus.wash_ticks = '0;
        bus.spin_ticks = '0;

        repeat (3) step();
        chk_idle("in_reset");
        reset = 1'b1;
        step();
        chk_idle("after_reset");

        // Directed cases.
        run_txn(0, 3, 0, 0, 0, 0, 0);   // 12-cycle wash
        run_txn(0, 3, 0, 1, 5, 5, 0);   // 5 paused cycles -> 17
        run_txn(2, 3, 2, 0, 0, 0, 0);   // both requests: wash wins
        run_txn(1, 0, 2, 0, 0, 0, 0);   // spin only -> 8
        run_txn(0, 0, 0, 0, 0, 0, 0);   // zero duration -> 1
        run_txn(0, 3, 0, 0, 0, 0, 6);   // abort at cycle 6
        run_txn(1, 0, 0, 1, 1, 3, 0);   // zero duration spin behind a pause

        // Reset in the middle of a wash.
        bus.wash_ticks = W'(3);
        bus.wash_run   = 1'b1;
        step();
        repeat (5) step();
        #2;
        reset = 1'b0;
        #1;
        chk_idle("async_reset");
        bus.wash_run = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk_idle("post_reset");
        run_txn(0, 3, 0, 0, 0, 0, 0);

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            run_txn(int'($urandom_range(0, 2)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 4)),
                    ($urandom_range(0, 1) == 1) ? 2 : 0, 0, 0,
                    ($urandom_range(0, 4) == 0) ? -1 : 0);
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (3) step();
        chk("scoreboard_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
